dmem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the single-port 2K x 32 data RAM of the Harvard MIPS core.
- Shares the RAM between requester A (pipeline MEM stage) and requester B (interrupt/call stack unit that pushes and pops the PC).
- Latches the winning command, drives the RAM for exactly one cycle and returns registered read data.
- Replaces direct MEM-stage wiring of the RAM's addr/dataIn/wen pins.

---
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port data RAM; one RAM access per BUSY cycle.
// Optional round-robin IDLE tie-break is enabled by defining DMEM_ARB_RR_EN.
module dmem_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reqA,
  input  logic              wenA,
  input  logic [ADDR_W-1:0] addrA,
  input  logic [DATA_W-1:0] dataInA,
  output logic              gntA,
  output logic              rvalidA,
  output logic [DATA_W-1:0] rdataA,
  input  logic              reqB,
  input  logic              wenB,
  input  logic [ADDR_W-1:0] addrB,
  input  logic [DATA_W-1:0] dataInB,
  output logic              gntB,
  output logic              rvalidB,
  output logic [DATA_W-1:0] rdataB,
  output logic [ADDR_W-1:0] ramAddr,
  output logic [DATA_W-1:0] ramDataIn,
  output logic              ramWen,
  input  logic [DATA_W-1:0] ramData,
  output logic              busy,
  output logic [1:0]        o_dbg_state
);

  // Handshake: a requester holds req and its fields stable until it sees gnt
  // high for one cycle; read data follows one cycle later with rvalid.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_A = 2'd1,
    S_BUSY_B = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_tie_a;
  logic                r_wen;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_din;
  logic                r_rvalid_a;
  logic                r_rvalid_b;
  logic [DATA_W-1:0]   r_rdata_a;
  logic [DATA_W-1:0]   r_rdata_b;

`ifdef DMEM_ARB_RR_EN
  // 1 = B was granted most recently; reset to B so A wins the first tie.
  logic r_last_gnt_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_gnt_b <= 1'b1;
    end else if (r_state == S_BUSY_A) begin
      r_last_gnt_b <= 1'b0;
    end else if (r_state == S_BUSY_B) begin
      r_last_gnt_b <= 1'b1;
    end
  end

  assign w_tie_a = r_last_gnt_b;
`else
  assign w_tie_a = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The requester being served is ignored; the other one may follow immediately.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (reqA && reqB) begin
          w_next = w_tie_a ? S_BUSY_A : S_BUSY_B;
        end else if (reqA) begin
          w_next = S_BUSY_A;
        end else if (reqB) begin
          w_next = S_BUSY_B;
        end
      end
      S_BUSY_A: w_next = reqB ? S_BUSY_B : S_IDLE;
      S_BUSY_B: w_next = reqA ? S_BUSY_A : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    gntA        = (r_state == S_BUSY_A);
    gntB        = (r_state == S_BUSY_B);
    busy        = (r_state == S_BUSY_A) || (r_state == S_BUSY_B);
    ramWen      = r_wen && busy && !rst;
    o_dbg_state = r_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen      <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
      r_rdata_a  <= '0;
      r_rdata_b  <= '0;
    end else begin
      r_rvalid_a <= (r_state == S_BUSY_A) && !r_wen;
      r_rvalid_b <= (r_state == S_BUSY_B) && !r_wen;
      if ((r_state == S_BUSY_A) && !r_wen) begin
        r_rdata_a <= ramData;
      end
      if ((r_state == S_BUSY_B) && !r_wen) begin
        r_rdata_b <= ramData;
      end
      // Latch the winner's command on entry; hold it through IDLE.
      if (w_next == S_BUSY_A) begin
        r_addr <= addrA;
        r_din  <= dataInA;
        r_wen  <= wenA;
      end else if (w_next == S_BUSY_B) begin
        r_addr <= addrB;
        r_din  <= dataInB;
        r_wen  <= wenB;
      end
    end
  end

  assign ramAddr   = r_addr;
  assign ramDataIn = r_din;
  assign rvalidA   = r_rvalid_a;
  assign rvalidB   = r_rvalid_b;
  assign rdataA    = r_rdata_a;
  assign rdataB    = r_rdata_b;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: RAM model, transaction-level reference compared every cycle,
// plus directed scenarios with literal expectations. Honours DMEM_ARB_RR_EN.
module tb_dmem_arbiter;
  localparam int AW = 11;
  localparam int DW = 32;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          reqA = 1'b0, wenA = 1'b0, reqB = 1'b0, wenB = 1'b0;
  logic [AW-1:0] addrA = '0, addrB = '0;
  logic [DW-1:0] dataInA = '0, dataInB = '0;
  logic          gntA, rvalidA, gntB, rvalidB, ramWen, busy;
  logic [DW-1:0] rdataA, rdataB, ramDataIn, ramData;
  logic [AW-1:0] ramAddr;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .reqA(reqA), .wenA(wenA), .addrA(addrA), .dataInA(dataInA),
    .gntA(gntA), .rvalidA(rvalidA), .rdataA(rdataA),
    .reqB(reqB), .wenB(wenB), .addrB(addrB), .dataInB(dataInB),
    .gntB(gntB), .rvalidB(rvalidB), .rdataB(rdataB),
    .ramAddr(ramAddr), .ramDataIn(ramDataIn), .ramWen(ramWen), .ramData(ramData),
    .busy(busy), .o_dbg_state(dbg_state)
  );

  // clock / RAM
  always #5 clk = ~clk;

  logic [DW-1:0] ram [0:2047];
  assign ramData = ram[ramAddr];
  always @(posedge clk) if (ramWen) ram[ramAddr] <= ramDataIn;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
    end
  endtask

  // Reference: each cycle at most one grant, given to a requester whose req was
  // high at the previous edge and who was not granted in the previous cycle.
  logic [DW-1:0] mdl_mem [0:2047];
  logic          m_gA = 0, m_gB = 0, m_wen = 0, m_rvA = 0, m_rvB = 0, m_last_b = 1;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_din = '0, m_rdA = '0, m_rdB = '0;

  always @(negedge clk) begin : compare
    logic ea, eb, pick_a, n_gA, n_gB;
    chk("gntA", 32'(gntA), 32'(m_gA));
    chk("gntB", 32'(gntB), 32'(m_gB));
    chk("busy", 32'(busy), 32'(m_gA | m_gB));
    chk("ramWen", 32'(ramWen), 32'((m_gA | m_gB) & m_wen & !rst));
    chk("ramAddr", 32'(ramAddr), 32'(m_addr));
    chk("ramDataIn", ramDataIn, m_din);
    chk("rvalidA", 32'(rvalidA), 32'(m_rvA));
    chk("rvalidB", 32'(rvalidB), 32'(m_rvB));
    chk("rdataA", rdataA, m_rdA);
    chk("rdataB", rdataB, m_rdB);
    if (rst) begin
      m_gA = 0; m_gB = 0; m_wen = 0; m_rvA = 0; m_rvB = 0; m_last_b = 1;
      m_addr = '0; m_din = '0; m_rdA = '0; m_rdB = '0;
    end else begin
      if ((m_gA | m_gB) && m_wen) mdl_mem[m_addr] = m_din;
      m_rvA = m_gA && !m_wen;
      m_rvB = m_gB && !m_wen;
      if (m_rvA) m_rdA = mdl_mem[m_addr];
      if (m_rvB) m_rdB = mdl_mem[m_addr];
      if (m_gA) m_last_b = 0;
      if (m_gB) m_last_b = 1;
      ea = reqA && !m_gA;
      eb = reqB && !m_gB;
      pick_a = RR ? m_last_b : 1'b1;
      if (ea && eb) begin
        n_gA = pick_a; n_gB = !pick_a;
      end else begin
        n_gA = ea; n_gB = eb;
      end
      m_gA = n_gA;
      m_gB = n_gB;
      if (n_gA) begin
        m_addr = addrA; m_din = dataInA; m_wen = wenA;
      end else if (n_gB) begin
        m_addr = addrB; m_din = dataInB; m_wen = wenB;
      end
    end
  end

  // driver tasks
  logic          cap_wen;
  logic [AW-1:0] cap_addr;

  task automatic access(input logic ea, input logic wa, input logic [AW-1:0] aa,
                        input logic [DW-1:0] da, input logic eb, input logic wb,
                        input logic [AW-1:0] ab, input logic [DW-1:0] db,
                        output string order);
    logic done_a, done_b;
    int n;
    @(posedge clk); #1;
    reqA = ea; wenA = wa; addrA = aa; dataInA = da;
    reqB = eb; wenB = wb; addrB = ab; dataInB = db;
    done_a = !ea; done_b = !eb; n = 0; order = "";
    while (!(done_a && done_b) && n < 8) begin
      @(negedge clk);
      if (gntA && !done_a) begin
        done_a = 1; order = {order, "A"}; cap_wen = ramWen; cap_addr = ramAddr;
      end
      if (gntB && !done_b) begin
        done_b = 1; order = {order, "B"};
      end
      @(posedge clk); #1;
      if (done_a) reqA = 0;
      if (done_b) reqB = 0;
      n++;
    end
    chk("grant_timeout", 32'({done_a, done_b}), 32'd3);
    reqA = 0; reqB = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic hold_reads(input int cycles, output string order);
    @(posedge clk); #1;
    reqA = 1; wenA = 0; addrA = 11'h069;
    reqB = 1; wenB = 0; addrB = 11'h047;
    order = "";
    repeat (cycles + 1) begin
      @(negedge clk);
      if (gntA) order = {order, "A"};
      if (gntB) order = {order, "B"};
    end
    @(posedge clk); #1;
    reqA = 0; reqB = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    string ord;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_gntA", 32'(gntA), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rdataA", rdataA, 32'd0);
    chk("reset_ramAddr", 32'(ramAddr), 32'd0);

    access(1, 1, 11'h069, 32'hABCD1234, 0, 0, '0, '0, ord);
    chk_str("write_order", ord, "A");
    chk("write_ramWen", 32'(cap_wen), 32'd1);
    chk("write_ramAddr", 32'(cap_addr), 32'h069);
    chk("write_no_rvalidA", 32'(rvalidA), 32'd0);

    access(1, 0, 11'h069, '0, 0, 0, '0, '0, ord);
    chk("readback_rdataA", rdataA, 32'hABCD1234);

    access(1, 1, 11'h047, 32'hBABA1111, 1, 1, 11'h066, 32'hFAFADEDE, ord);
    chk_str("contention_order", ord, RR ? "BA" : "AB");

    access(1, 0, 11'h066, '0, 1, 0, 11'h047, '0, ord);
    chk_str("cross_read_order", ord, RR ? "BA" : "AB");
    chk("cross_rdataB", rdataB, 32'hBABA1111);
    chk("cross_rdataA", rdataA, 32'hFAFADEDE);

    hold_reads(6, ord);
    chk_str("alternation", ord, RR ? "BABABA" : "ABABAB");

    access(1, 1, 11'h7FF, 32'h5A5A5A5A, 1, 1, 11'h000, 32'h00C0FFEE, ord);
    access(1, 0, 11'h000, '0, 1, 0, 11'h7FF, '0, ord);
    chk("edge_rdataA_0x000", rdataA, 32'h00C0FFEE);
    chk("edge_rdataB_0x7ff", rdataB, 32'h5A5A5A5A);

    // reset arriving during a BUSY_B write
    @(posedge clk); #1;
    reqB = 1; wenB = 1; addrB = 11'h066; dataInB = 32'h11112222;
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("rstmid_gntB", 32'(gntB), 32'd1);
    chk("rstmid_ramWen", 32'(ramWen), 32'd0);
    @(posedge clk); #1;
    rst = 0; reqB = 0;
    @(negedge clk);
    chk("rstmid_after_gntB", 32'(gntB), 32'd0);
    chk("rstmid_after_rdataA", rdataA, 32'd0);
    chk("rstmid_after_ramAddr", 32'(ramAddr), 32'd0);
    chk("rstmid_ram_kept", ram[11'h066], 32'hFAFADEDE);

    access(1, 0, 11'h069, '0, 0, 0, '0, '0, ord);
    chk("indep_rdataA", rdataA, 32'hABCD1234);
    chk("indep_rdataB_untouched", rdataB, 32'd0);
    access(0, 0, '0, '0, 1, 0, 11'h047, '0, ord);
    chk("indep_rdataB", rdataB, 32'hBABA1111);
    chk("indep_rdataA_kept", rdataA, 32'hABCD1234);
    access(0, 0, '0, '0, 1, 0, 11'h066, '0, ord);
    chk("rstmid_readback", rdataB, 32'hFAFADEDE);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
